// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters onto one HPDcache port, sid = requester+1; responses routed back by sid.
// Latency: zero-cycle request path and zero-cycle response routing; state updates on the next clk_i edge.
// Backpressure: a stalled grant stays locked until dcache_ready_i. DCACHE_ARB_FIXED_PRIO_EN selects fixed priority.
package hpdcache_pkg;
  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD, HPDCACHE_REQ_STORE, HPDCACHE_REQ_CMO,
    HPDCACHE_REQ_AMO_LR, HPDCACHE_REQ_AMO_SC, HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD,
    HPDCACHE_REQ_AMO_AND, HPDCACHE_REQ_AMO_OR, HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX,
    HPDCACHE_REQ_AMO_MAXU, HPDCACHE_REQ_AMO_MIN, HPDCACHE_REQ_AMO_MINU
  } hpdcache_req_op_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      wdata;
    hpdcache_req_op_t op;
    logic             need_rsp;
    logic [2:0]       sid;
    logic [3:0]       tid;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  sid;
    logic [3:0]  tid;
    logic        error;
  } hpdcache_rsp_t;

  function automatic logic is_amo(input hpdcache_req_op_t op);
    return (op >= HPDCACHE_REQ_AMO_LR) && (op <= HPDCACHE_REQ_AMO_MINU);
  endfunction
endpackage

module dcache_req_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic          [NUM_REQ-1:0]  req_valid_i,
  output logic          [NUM_REQ-1:0]  req_ready_o,
  input  hpdcache_req_t [NUM_REQ-1:0]  req_i,
  output logic          [NUM_REQ-1:0]  rsp_valid_o,
  output hpdcache_rsp_t                rsp_o,
  output logic                         core_req_valid_o,
  input  logic                         dcache_ready_i,
  output hpdcache_req_t                req_dcache_o,
  input  logic                         dcache_valid_i,
  input  hpdcache_rsp_t                rsp_dcache_i,
  input  logic                         drain_i,
  output logic                         drained_o,
  output logic                         sid_err_o
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {RUN, AMO_WAIT, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]               lock_idx_q, lock_idx_d;
  logic                        lock_q, lock_d;
  logic [NUM_REQ-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [2:0]                  amo_sid_q, amo_sid_d;
  logic [3:0]                  amo_tid_q, amo_tid_d;

  logic [NUM_REQ-1:0] elig, inc_v;
  logic [PW-1:0]      win;
  logic               found, hs, cnt_zero_hit, all_zero, amo_done;

  // Only requests that expect a response consume an outstanding slot.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      elig[i] = req_valid_i[i] && (!req_i[i].need_rsp || (cnt_q[i] < CNT_MAX));
    end
  end

  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
      if (!found && elig[j[PW-1:0]]) begin
        found = 1'b1;
        win   = j[PW-1:0];
      end
    end
    if (lock_q) begin
      found = 1'b1;
      win   = lock_idx_q;
    end
  end

  always_comb begin
    core_req_valid_o = rstn_i && (state_q == RUN) && found;
    hs               = core_req_valid_o && dcache_ready_i;
    req_ready_o      = hs ? (NUM_REQ'(1) << win) : '0;
    req_dcache_o     = req_i[win];
    req_dcache_o.sid = 3'(win) + 3'd1;
  end

  // Response routing; an unmapped sid matches no bit and so never touches a counter.
  always_comb begin
    rsp_o        = rsp_dcache_i;
    cnt_zero_hit = 1'b0;
    all_zero     = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid_o[i] = dcache_valid_i && (rsp_dcache_i.sid == 3'(i + 1));
      if (rsp_valid_o[i] && (cnt_q[i] == '0)) cnt_zero_hit = 1'b1;
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
    sid_err_o = rstn_i && dcache_valid_i && (!(|rsp_valid_o) || cnt_zero_hit);
    drained_o = (state_q == DRAIN) && all_zero;
    amo_done  = dcache_valid_i && (rsp_dcache_i.sid == amo_sid_q) && (rsp_dcache_i.tid == amo_tid_q);
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      inc_v[i] = hs && (win == PW'(i)) && req_dcache_o.need_rsp;
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !rsp_valid_o[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rsp_valid_o[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    amo_sid_d  = amo_sid_q;
    amo_tid_d  = amo_tid_q;

    if (hs) begin
      lock_d   = 1'b0;
      rr_ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (core_req_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win;
    end
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`endif

    // An AMO handshake wins over a simultaneous drain request; drain follows its response.
    case (state_q)
      RUN: begin
        if (hs && is_amo(req_dcache_o.op)) begin
          state_d   = AMO_WAIT;
          amo_sid_d = req_dcache_o.sid;
          amo_tid_d = req_dcache_o.tid;
        end else if (drain_i && !lock_d) begin
          state_d = DRAIN;
        end
      end
      AMO_WAIT: if (amo_done) state_d = drain_i ? DRAIN : RUN;
      DRAIN:    if (!drain_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      amo_sid_q  <= '0;
      amo_tid_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
      amo_sid_q  <= amo_sid_d;
      amo_tid_q  <= amo_tid_d;
    end
  end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter (default round-robin build, NUM_REQ=3, MAX_OUTSTANDING=8).
module tb_dcache_req_arbiter;
  import hpdcache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [2:0]            req_valid;
  logic [2:0]            req_ready;
  hpdcache_req_t [2:0]   req;
  logic [2:0]            rsp_valid;
  hpdcache_rsp_t         rsp_out;
  logic                  core_valid;
  logic                  dc_ready;
  hpdcache_req_t         req_dc;
  logic                  dc_valid;
  hpdcache_rsp_t         dc_rsp;
  logic                  drain;
  logic                  drained;
  logic                  sid_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_req_arbiter #(.NUM_REQ(3), .MAX_OUTSTANDING(8)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_i            (req),
    .rsp_valid_o      (rsp_valid),
    .rsp_o            (rsp_out),
    .core_req_valid_o (core_valid),
    .dcache_ready_i   (dc_ready),
    .req_dcache_o     (req_dc),
    .dcache_valid_i   (dc_valid),
    .rsp_dcache_i     (dc_rsp),
    .drain_i          (drain),
    .drained_o        (drained),
    .sid_err_o        (sid_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    dc_ready  = 1'b0;
    dc_valid  = 1'b0;
    dc_rsp    = '0;
    drain     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i].addr     = 32'h100 + 32'(i);
      req[i].wdata    = 32'h0;
      req[i].op       = HPDCACHE_REQ_LOAD;
      req[i].need_rsp = 1'b1;
      req[i].sid      = 3'd7;
      req[i].tid      = 4'(i);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic respond(input logic [2:0] sid, input logic [3:0] tid);
    dc_valid     = 1'b1;
    dc_rsp.sid   = sid;
    dc_rsp.tid   = tid;
    dc_rsp.rdata = 32'hCAFE0000 + 32'(sid);
  endtask

  initial begin
    // Reset state with live inputs: only response routing is visible.
    rstn = 1'b0;
    idle();
    req_valid = 3'b111;
    dc_ready  = 1'b1;
    respond(3'd2, 4'd0);
    #3;
    check_eq("rst_core_valid", 32'(core_valid), 32'd0);
    check_eq("rst_req_ready",  32'(req_ready),  32'd0);
    check_eq("rst_drained",    32'(drained),    32'd0);
    check_eq("rst_sid_err",    32'(sid_err),    32'd0);
    check_eq("rst_rsp_valid",  32'(rsp_valid),  32'b010);

    // Round-robin with all requesters valid.
    do_reset();
    req_valid = 3'b111;
    dc_ready  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("rr_grant", 32'(req_ready),   32'(3'b001 << (c % 3)));
      check_eq("rr_sid",   32'(req_dc.sid),  32'(c % 3 + 1));
      check_eq("rr_addr",  req_dc.addr,      32'h100 + 32'(c % 3));
      cyc();
    end

    // Stalled grant stays locked on requester 1 while requester 0 appears.
    do_reset();
    req_valid = 3'b010;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_valid = 3'b011;
      #1;
      check_eq("lock_valid", 32'(core_valid),  32'd1);
      check_eq("lock_ready", 32'(req_ready),   32'd0);
      check_eq("lock_sid",   32'(req_dc.sid),  32'd2);
      check_eq("lock_addr",  req_dc.addr,      32'h101);
      cyc();
    end
    dc_ready = 1'b1;
    #1;
    check_eq("lock_hs", 32'(req_ready), 32'b010);
    cyc();
    #1;
    check_eq("lock_next", 32'(req_ready),  32'b001);
    check_eq("lock_next_sid", 32'(req_dc.sid), 32'd1);
    cyc();

    // Outstanding limit on requester 0.
    do_reset();
    req_valid = 3'b001;
    dc_ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("out_fill", 32'(req_ready), 32'b001);
      cyc();
    end
    #1;
    check_eq("out_block", 32'(core_valid), 32'd0);
    cyc();
    req_valid = 3'b011;
    #1;
    check_eq("out_other", 32'(req_ready), 32'b010);
    cyc();
    req_valid = 3'b001;
    respond(3'd1, 4'd0);
    #1;
    check_eq("out_rsp_route", 32'(rsp_valid), 32'b001);
    check_eq("out_rsp_data",  rsp_out.rdata,  32'hCAFE0001);
    check_eq("out_still_blk", 32'(core_valid), 32'd0);
    check_eq("out_no_err",    32'(sid_err),    32'd0);
    cyc();
    dc_valid = 1'b0;
    #1;
    check_eq("out_reopen", 32'(req_ready), 32'b001);
    cyc();

    // AMO blocks grants until its own sid/tid response.
    do_reset();
    req[2].op  = HPDCACHE_REQ_AMO_ADD;
    req[2].tid = 4'd5;
    req_valid  = 3'b100;
    dc_ready   = 1'b1;
    #1;
    check_eq("amo_grant", 32'(req_ready),  32'b100);
    check_eq("amo_sid",   32'(req_dc.sid), 32'd3);
    cyc();
    req[2].op = HPDCACHE_REQ_LOAD;
    req_valid = 3'b111;
    #1;
    check_eq("amo_wait", 32'(core_valid), 32'd0);
    cyc();
    respond(3'd3, 4'd4);
    #1;
    check_eq("amo_wrong_tid", 32'(core_valid), 32'd0);
    check_eq("amo_rsp_route", 32'(rsp_valid),  32'b100);
    cyc();
    respond(3'd3, 4'd5);
    #1;
    check_eq("amo_rsp_cycle", 32'(core_valid), 32'd0);
    cyc();
    dc_valid = 1'b0;
    #1;
    check_eq("amo_resume", 32'(req_ready), 32'b001);
    cyc();

    // Drain with two loads in flight.
    do_reset();
    req_valid = 3'b001;
    dc_ready  = 1'b1;
    cyc();
    cyc();
    req_valid = 3'b000;
    drain     = 1'b1;
    #1;
    check_eq("drn_enter", 32'(drained), 32'd0);
    cyc();
    req_valid = 3'b001;
    respond(3'd1, 4'd0);
    #1;
    check_eq("drn_no_grant", 32'(core_valid), 32'd0);
    check_eq("drn_two",      32'(drained),    32'd0);
    cyc();
    #1;
    check_eq("drn_one", 32'(drained), 32'd0);
    cyc();
    dc_valid = 1'b0;
    #1;
    check_eq("drn_done", 32'(drained), 32'd1);
    cyc();
    drain = 1'b0;
    #1;
    check_eq("drn_release", 32'(core_valid), 32'd0);
    cyc();
    #1;
    check_eq("drn_resume", 32'(req_ready), 32'b001);
    cyc();

    // Unmapped sids and counter saturation.
    do_reset();
    req_valid = 3'b001;
    dc_ready  = 1'b1;
    cyc();
    req_valid = 3'b000;
    respond(3'd0, 4'd0);
    #1;
    check_eq("sid0_err",   32'(sid_err),   32'd1);
    check_eq("sid0_route", 32'(rsp_valid), 32'd0);
    cyc();
    respond(3'd5, 4'd0);
    #1;
    check_eq("sid5_err",   32'(sid_err),   32'd1);
    check_eq("sid5_route", 32'(rsp_valid), 32'd0);
    cyc();
    dc_valid = 1'b0;
    #1;
    check_eq("err_pulse_end", 32'(sid_err), 32'd0);
    cyc();
    respond(3'd1, 4'd0);
    #1;
    check_eq("cnt_kept", 32'(sid_err), 32'd0);
    cyc();
    #1;
    check_eq("cnt_sat_err", 32'(sid_err), 32'd1);
    cyc();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
